prog_sequencer: RTL and testbench

Program-flow sequencer for the 9-bit single-issue core. It owns the program counter and gates the decoder's write enables. It tracks the run state across start, execute, load-stall and halt, and resolves taken branches through a branch-target LUT. It sits between the testbench Start/Done handshake, the instruction ROM (addressed by `ProgCtr`) and the combinational control decoder, whose `BranchEn`/`LoadInst`/`Ack` flags it consumes.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/branch_lut.sv | 15 +
 rtl/prog_sequencer.sv | 161 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the program-flow sequencer: run-state enum,
// branch-target table contents and instruction-class opcodes.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

  localparam int BR_LUT_DEPTH = 32;
  localparam int BR_TGT_W     = 16;

  // Entries are stored wide; the LUT keeps the low PC_W bits.
  localparam logic [BR_TGT_W-1:0] BR_TARGETS [BR_LUT_DEPTH] = '{
    16'd0,   16'd2,   16'd10,  16'd3,   16'd40,  16'd50,  16'd60,  16'd20,
    16'd80,  16'd90,  16'd100, 16'd110, 16'd120, 16'd130, 16'd140, 16'd150,
    16'd160, 16'd170, 16'd180, 16'd190, 16'd200, 16'd210, 16'd220, 16'd230,
    16'd240, 16'd250, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700, 16'd1023
  };

  // Instruction[8:5] class codes; the halt word is all ones.
  localparam logic [3:0] OP_BRANCH  = 4'b1010;
  localparam logic [3:0] OP_LOAD    = 4'b0110;
  localparam logic [8:0] INSTR_HALT = 9'h1FF;

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target ROM: 5-bit index to PC_W-bit target address.
module branch_lut
  import seq_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [4:0]      idx,
  output logic [PC_W-1:0] target
);

  always_comb begin
    target = BR_TARGETS[idx][PC_W-1:0];
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program counter / run-state sequencer with load stall and watchdog.
// Optional PROG_SEQ_PERF_EN adds saturating CycleCnt/InstrCnt outputs.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int MEM_LAT    = 1,
  parameter int MAX_CYCLES = 4095
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            BranchEn,
  input  logic            LoadInst,
  input  logic            Ack,
  input  logic            CondFlag,
  output logic [PC_W-1:0] ProgCtr,
  output logic            ExecEn,
  output logic            Running,
  output logic            Done,
  output logic            Fault,
`ifdef PROG_SEQ_PERF_EN
  output logic [15:0]     CycleCnt,
  output logic [15:0]     InstrCnt,
`endif
  output seq_state_t      dbg_state
);

  localparam int              WD_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(MAX_CYCLES);
  localparam logic [2:0]      WAIT_INIT = 3'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      wait_q, wait_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            fault_q, fault_d;
  logic            exec_en;
  logic [PC_W-1:0] br_target;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^Instruction[8:5];

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx    (Instruction[4:0]),
    .target (br_target)
  );

  // Handshake: Start is a level; the program launches when Start falls in
  // ARMED, and Done stays high in HALT until the next Start.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    wd_d    = wd_q;
    fault_d = fault_q;
    exec_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = ARMED;
          pc_d    = '0;
        end
      end
      ARMED: begin
        pc_d = '0;
        if (!Start) begin
          state_d = RUN;
          wd_d    = '0;
        end
      end
      RUN, WAIT: begin
        if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
        // Watchdog expiry overrides whatever the current cycle would do.
        if (wd_d == WD_MAX) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else if (state_q == RUN) begin
          if (Ack) begin
            state_d = HALT;
          end else if (LoadInst && (MEM_LAT > 0)) begin
            state_d = WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            exec_en = 1'b1;
            pc_d    = (BranchEn && CondFlag) ? br_target : pc_q + PC_W'(1);
          end
        end else if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else begin
          exec_en = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = RUN;
        end
      end
      HALT: begin
        if (Start) begin
          state_d = ARMED;
          pc_d    = '0;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign ExecEn    = exec_en;
  assign Running   = (state_q == RUN) || (state_q == WAIT);
  assign Done      = (state_q == HALT);
  assign Fault     = fault_q;
  assign dbg_state = state_q;

`ifdef PROG_SEQ_PERF_EN
  logic [15:0] cycle_q, cycle_d;
  logic [15:0] instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if ((state_d == ARMED) && (state_q != ARMED)) begin
      cycle_d = '0;
      instr_d = '0;
    end else begin
      if (Running && (cycle_q != 16'hFFFF)) cycle_d = cycle_q + 16'd1;
      if (exec_en && (instr_q != 16'hFFFF)) instr_d = instr_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign CycleCnt = cycle_q;
  assign InstrCnt = instr_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer (MEM_LAT=2, MAX_CYCLES=50) with a
// behavioural ROM and decoder driving the flag inputs.
module tb_prog_sequencer;
  import seq_pkg::*;

  localparam int PC_W       = 10;
  localparam int MEM_LAT    = 2;
  localparam int MAX_CYCLES = 50;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic            CondFlag;
  logic [8:0]      Instruction;
  logic            BranchEn;
  logic            LoadInst;
  logic            Ack;
  logic [PC_W-1:0] ProgCtr;
  logic            ExecEn;
  logic            Running;
  logic            Done;
  logic            Fault;
  seq_state_t      dbg_state;
`ifdef PROG_SEQ_PERF_EN
  logic [15:0]     CycleCnt;
  logic [15:0]     InstrCnt;
`endif

  logic [8:0] rom [1024];
  int checks = 0;
  int errors = 0;

  assign Instruction = rom[ProgCtr];
  assign Ack         = (Instruction == INSTR_HALT);
  assign LoadInst    = (Instruction[8:5] == OP_LOAD);
  assign BranchEn    = (Instruction[8:5] == OP_BRANCH);

  prog_sequencer #(
    .PC_W(PC_W), .MEM_LAT(MEM_LAT), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .BranchEn(BranchEn), .LoadInst(LoadInst), .Ack(Ack), .CondFlag(CondFlag),
    .ProgCtr(ProgCtr), .ExecEn(ExecEn), .Running(Running), .Done(Done),
    .Fault(Fault),
`ifdef PROG_SEQ_PERF_EN
    .CycleCnt(CycleCnt), .InstrCnt(InstrCnt),
`endif
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 9'h001;
  endtask

  task automatic start_prog();
    Start = 1'b1;
    step();
    check("armed_state", 16'(dbg_state), 16'(ARMED));
    check("armed_pc", 16'(ProgCtr), 16'd0);
    check("armed_done", 16'(Done), 16'd0);
    check("armed_fault", 16'(Fault), 16'd0);
    Start = 1'b0;
    step();
    check("run_state", 16'(dbg_state), 16'(RUN));
    check("run_pc0", 16'(ProgCtr), 16'd0);
  endtask

  initial begin
    int exec_cnt;
    int run_cnt;

    // Reset and idle hold
    Reset = 1'b0; Start = 1'b0; CondFlag = 1'b0;
    clear_rom();
    step(); step();
    Reset = 1'b1;
    check("rst_exec", 16'(ExecEn), 16'd0);
    check("rst_running", 16'(Running), 16'd0);
    check("rst_done", 16'(Done), 16'd0);
    check("rst_fault", 16'(Fault), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_state", 16'(dbg_state), 16'(IDLE));
      check("idle_pc", 16'(ProgCtr), 16'd0);
    end

    // Five ALU ops then halt
    rom[5] = INSTR_HALT;
    start_prog();
    exec_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      check("seq_pc", 16'(ProgCtr), 16'(k));
      check("seq_exec", 16'(ExecEn), 16'd1);
      exec_cnt += int'(ExecEn);
      step();
    end
    check("halt_pc", 16'(ProgCtr), 16'd5);
    check("halt_exec", 16'(ExecEn), 16'd0);
    check("halt_done_early", 16'(Done), 16'd0);
    exec_cnt += int'(ExecEn);
    step();
    exec_cnt += int'(ExecEn);
    check("halt_done", 16'(Done), 16'd1);
    check("halt_pc_frozen", 16'(ProgCtr), 16'd5);
    check("halt_running", 16'(Running), 16'd0);
    check("exec_count", 16'(exec_cnt), 16'd5);

    // Load at address 3 with MEM_LAT=2
    clear_rom();
    rom[3] = {OP_LOAD, 5'd0};
    rom[5] = INSTR_HALT;
    start_prog();
    step(); step(); step();
    check("ld_pc_a", 16'(ProgCtr), 16'd3);
    check("ld_exec_a", 16'(ExecEn), 16'd0);
    step();
    check("ld_pc_b", 16'(ProgCtr), 16'd3);
    check("ld_state_b", 16'(dbg_state), 16'(WAIT));
    check("ld_exec_b", 16'(ExecEn), 16'd0);
    step();
    check("ld_pc_c", 16'(ProgCtr), 16'd3);
    check("ld_exec_c", 16'(ExecEn), 16'd1);
    step();
    check("ld_pc_after", 16'(ProgCtr), 16'd4);
    check("ld_state_after", 16'(dbg_state), 16'(RUN));
    step(); step();
    check("ld_done", 16'(Done), 16'd1);

    // Taken branch through LUT entry 7
    clear_rom();
    rom[0]  = {OP_BRANCH, 5'd7};
    rom[20] = INSTR_HALT;
    CondFlag = 1'b1;
    start_prog();
    check("br_exec", 16'(ExecEn), 16'd1);
    step();
    check("br_taken_pc", 16'(ProgCtr), 16'd20);
    step();
    check("br_taken_done", 16'(Done), 16'd1);

    // Same branch not taken
    rom[1] = INSTR_HALT;
    CondFlag = 1'b0;
    start_prog();
    step();
    check("br_nt_pc", 16'(ProgCtr), 16'd1);
    step();
    check("br_nt_done", 16'(Done), 16'd1);

    // Self-branch loop at address 3 trips the watchdog
    clear_rom();
    rom[3] = {OP_BRANCH, 5'd3};
    CondFlag = 1'b1;
    start_prog();
    run_cnt = 0;
    for (int t = 0; t < 80 && !Done; t++) begin
      if (Running) run_cnt++;
      step();
    end
    check("wd_done", 16'(Done), 16'd1);
    check("wd_fault", 16'(Fault), 16'd1);
    check("wd_run_cycles", 16'(run_cnt), 16'd50);
    check("wd_pc", 16'(ProgCtr), 16'd3);
    start_prog();
    check("wd_rearm_fault", 16'(Fault), 16'd0);

    // Reset during a load stall
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    clear_rom();
    rom[0] = {OP_LOAD, 5'd0};
    rom[1] = INSTR_HALT;
    CondFlag = 1'b0;
    start_prog();
    check("rw_exec_run", 16'(ExecEn), 16'd0);
    step();
    check("rw_state_wait", 16'(dbg_state), 16'(WAIT));
    check("rw_exec_wait", 16'(ExecEn), 16'd0);
    Reset = 1'b0;
    step();
    check("rw_state_idle", 16'(dbg_state), 16'(IDLE));
    check("rw_exec", 16'(ExecEn), 16'd0);
    check("rw_pc", 16'(ProgCtr), 16'd0);
    check("rw_running", 16'(Running), 16'd0);
    Reset = 1'b1;
    step();
    check("rw_exec_after", 16'(ExecEn), 16'd0);
    check("rw_idle_after", 16'(dbg_state), 16'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
